// File: rtl/mult_fu_pipe.sv
// mult_fu_pipe: pipelined low-XLEN integer multiplier feeding the CDB, one W-bit multiplier slice per stage.
module mult_fu_pipe #(
  parameter int XLEN       = 64,
  parameter int NUM_STAGES = 4,
  parameter int TAG_W      = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [XLEN-1:0]  issue_opa,
  input  logic [XLEN-1:0]  issue_opb,
  input  logic             flush,
  input  logic             cdb_grant,
  output logic             fu_ready,
  output logic             cdb_req,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [XLEN-1:0]  cdb_result
);
  localparam int W = XLEN / NUM_STAGES;
  logic [NUM_STAGES-1:0] vld;
  logic [TAG_W-1:0]      tag     [NUM_STAGES];
  logic [XLEN-1:0]       mcand   [NUM_STAGES];
  logic [XLEN-1:0]       mplier  [NUM_STAGES];
  logic [XLEN-1:0]       partial [NUM_STAGES];
  logic                  stall;
  assign stall      = vld[NUM_STAGES-1] & ~cdb_grant;
  assign fu_ready   = ~stall;
  assign cdb_req    = vld[NUM_STAGES-1];
  assign cdb_tag    = tag[NUM_STAGES-1];
  assign cdb_result = partial[NUM_STAGES-1];
  // Stage data only moves behind a valid op, so bubbles never disturb the held result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        tag[k]     <= '0;
        mcand[k]   <= '0;
        mplier[k]  <= '0;
        partial[k] <= '0;
      end
    end else begin
      if (flush) vld <= '0;
      else if (!stall) vld <= {vld[NUM_STAGES-2:0], issue_valid};
      if (!stall) begin
        if (issue_valid && !flush) begin
          tag[0]     <= issue_tag;
          mcand[0]   <= issue_opa << W;
          mplier[0]  <= issue_opb >> W;
          partial[0] <= issue_opa * XLEN'(issue_opb[W-1:0]);
        end
        for (int k = 1; k < NUM_STAGES; k++) begin
          if (vld[k-1]) begin
            tag[k]     <= tag[k-1];
            mcand[k]   <= mcand[k-1] << W;
            mplier[k]  <= mplier[k-1] >> W;
            partial[k] <= partial[k-1] + mcand[k-1] * XLEN'(mplier[k-1][W-1:0]);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mult_fu_pipe.sv
// tb_mult_fu_pipe: directed checks of latency, throughput, stall, flush and async reset.
module tb_mult_fu_pipe;
  logic        clock = 0;
  logic        reset = 0;
  logic        issue_valid = 0;
  logic [5:0]  issue_tag = '0;
  logic [63:0] issue_opa = '0;
  logic [63:0] issue_opb = '0;
  logic        flush = 0;
  logic        cdb_grant = 1;
  logic        fu_ready;
  logic        cdb_req;
  logic [5:0]  cdb_tag;
  logic [63:0] cdb_result;
  int checks = 0;
  int failures = 0;
  logic [5:0]  bt [8];
  logic [63:0] ba [8];
  logic [63:0] bb [8];
  logic [63:0] br [8];
  mult_fu_pipe #(.XLEN(64), .NUM_STAGES(4), .TAG_W(6)) dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_tag(issue_tag),
    .issue_opa(issue_opa), .issue_opb(issue_opb), .flush(flush), .cdb_grant(cdb_grant),
    .fu_ready(fu_ready), .cdb_req(cdb_req), .cdb_tag(cdb_tag), .cdb_result(cdb_result)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask
  task automatic set_op(input int i, input logic [5:0] t, input logic [63:0] a, input logic [63:0] b, input logic [63:0] r);
    bt[i] = t; ba[i] = a; bb[i] = b; br[i] = r;
  endtask
  task automatic drive(input int i);
    issue_valid = 1; issue_tag = bt[i]; issue_opa = ba[i]; issue_opb = bb[i];
  endtask
  // Issues n ops back to back with grant high; results must follow 1/cycle after 4 cycles.
  task automatic burst(input int n, input string nm);
    for (int i = 0; i < n + 4; i++) begin
      if (i < n) drive(i);
      else issue_valid = 0;
      tick();
      chk({nm, "_ready"}, 64'(fu_ready), 64'd1);
      if (i >= 3 && i < n + 3) begin
        chk({nm, "_req"}, 64'(cdb_req), 64'd1);
        chk({nm, "_tag"}, 64'(cdb_tag), 64'(bt[i-3]));
        chk({nm, "_res"}, cdb_result, br[i-3]);
      end else chk({nm, "_idle"}, 64'(cdb_req), 64'd0);
    end
    issue_valid = 0;
  endtask
  initial begin
    #3;
    chk("rst_req", 64'(cdb_req), 64'd0);
    chk("rst_tag", 64'(cdb_tag), 64'd0);
    chk("rst_res", cdb_result, 64'd0);
    chk("rst_ready", 64'(fu_ready), 64'd1);
    tick();
    tick();
    reset = 1;
    set_op(0, 6'd12, 64'd3, 64'd5, 64'd15);
    burst(1, "single");
    set_op(0, 6'd1, 64'd2, 64'd3, 64'd6);
    set_op(1, 6'd2, 64'd4, 64'd5, 64'd20);
    set_op(2, 6'd3, 64'd6, 64'd7, 64'd42);
    set_op(3, 6'd4, 64'd8, 64'd9, 64'd72);
    burst(4, "b2b");
    for (int i = 0; i < 4; i++) begin
      drive(i);
      tick();
      chk("st_issue_ready", 64'(fu_ready), 64'd1);
    end
    chk("st_first_req", 64'(cdb_req), 64'd1);
    cdb_grant = 0;
    issue_valid = 1; issue_tag = 6'd9; issue_opa = 64'd100; issue_opb = 64'd100;
    #1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) tick();
      chk("st_ready", 64'(fu_ready), 64'd0);
      chk("st_req", 64'(cdb_req), 64'd1);
      chk("st_tag", 64'(cdb_tag), 64'd1);
      chk("st_res", cdb_result, 64'd6);
    end
    cdb_grant = 1;
    issue_valid = 0;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("st_drain_req", 64'(cdb_req), 64'd1);
      chk("st_drain_tag", 64'(cdb_tag), 64'(bt[i]));
      chk("st_drain_res", cdb_result, br[i]);
    end
    tick();
    chk("st_empty", 64'(cdb_req), 64'd0);
    set_op(0, 6'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    set_op(1, 6'd6, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0);
    set_op(2, 6'd7, 64'h1234_5678_9ABC_DEF0, 64'h10, 64'h2345_6789_ABCD_EF00);
    set_op(3, 6'd8, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    burst(4, "wrap");
    set_op(0, 6'd1, 64'd11, 64'd11, 64'd121);
    set_op(1, 6'd2, 64'd12, 64'd12, 64'd144);
    set_op(2, 6'd3, 64'd13, 64'd13, 64'd169);
    for (int i = 0; i < 3; i++) begin
      drive(i);
      tick();
    end
    flush = 1;
    issue_valid = 1; issue_tag = 6'd13; issue_opa = 64'd2; issue_opb = 64'd2;
    tick();
    chk("fl_req", 64'(cdb_req), 64'd0);
    flush = 0;
    issue_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fl_after", 64'(cdb_req), 64'd0);
    end
    set_op(0, 6'd10, 64'd7, 64'd6, 64'd42);
    burst(1, "post_flush");
    set_op(0, 6'd2, 64'd9, 64'd9, 64'd81);
    set_op(1, 6'd3, 64'd10, 64'd10, 64'd100);
    for (int i = 0; i < 2; i++) begin
      drive(i);
      tick();
    end
    issue_valid = 0;
    tick();
    tick();
    chk("mr_req", 64'(cdb_req), 64'd1);
    chk("mr_res", cdb_result, 64'd81);
    #2;
    reset = 0;
    #1;
    chk("mr_rst_req", 64'(cdb_req), 64'd0);
    chk("mr_rst_tag", 64'(cdb_tag), 64'd0);
    chk("mr_rst_res", cdb_result, 64'd0);
    chk("mr_rst_ready", 64'(fu_ready), 64'd1);
    tick();
    reset = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mr_stale", 64'(cdb_req), 64'd0);
    end
    set_op(0, 6'd63, 64'd1000, 64'd1000, 64'd1000000);
    burst(1, "post_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
